alu_exec_ctrl: RTL



---
 rtl/alu_ctrl_pkg.sv | 51 +++++
 rtl/alu_exec_ctrl_alu.sv | 45 ++++
 rtl/alu_exec_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the AC/DR/E execution controller: opcodes, ALU
// op-select codes, FSM states and opcode classification helpers.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_CMA = 4'h3;
  localparam logic [3:0] OP_CIR = 4'h4;
  localparam logic [3:0] OP_CIL = 4'h5;
  localparam logic [3:0] OP_CLA = 4'h6;
  localparam logic [3:0] OP_CLE = 4'h7;
  localparam logic [3:0] OP_CME = 4'h8;
  localparam logic [3:0] OP_SZA = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_LDA = 3'b010;
  localparam logic [2:0] ALU_CMA = 3'b011;
  localparam logic [2:0] ALU_CIR = 3'b100;
  localparam logic [2:0] ALU_CIL = 3'b101;
  localparam logic [2:0] ALU_CLA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_EXEC,
    ST_DONE
  } state_t;

  // Operations that need a memory operand fetched into DR first.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA);
  endfunction

  // ALU op-select for a given opcode; INC reuses the adder.
  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_AND:         return ALU_AND;
      OP_ADD, OP_INC: return ALU_ADD;
      OP_LDA:         return ALU_LDA;
      OP_CMA:         return ALU_CMA;
      OP_CIR:         return ALU_CIR;
      OP_CIL:         return ALU_CIL;
      OP_CLA:         return ALU_CLA;
      default:        return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_alu.sv
// Combinational 16-bit ALU: logic, add with carry/overflow, rotates through E.
module alu_exec_ctrl_alu
  import alu_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         e_in,
  input  logic [2:0]   op_sel,
  output logic [W-1:0] y,
  output logic         co,
  output logic         ovf
);

  logic [W:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  // Result, carry-out and signed overflow for the selected operation.
  always_comb begin
    y   = '0;
    co  = 1'b0;
    ovf = 1'b0;
    case (op_sel)
      ALU_AND: y = a & b;
      ALU_ADD: begin
        y   = sum[W-1:0];
        co  = sum[W];
        ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_LDA: y = b;
      ALU_CMA: y = ~a;
      ALU_CIR: begin
        y  = {e_in, a[W-1:1]};
        co = a[0];
      end
      ALU_CIL: begin
        y  = {a[W-2:0], e_in};
        co = a[W-1];
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Accumulator sequencer around the ALU: accepts one command at a time,
// fetches memory operands into DR, and writes back AC, E and ovf.
// Optional feature macro: ALU_CTRL_INC_EN enables opcode A (INC).
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [W-1:0]  mem_rdata,
  output logic          done,
  output logic          err,
  output logic          skip,
  output logic [W-1:0]  ac,
  output logic          e,
  output logic          ovf,
  output logic          n,
  output logic          z
);

`ifdef ALU_CTRL_INC_EN
  localparam bit IncEn = 1'b1;
`else
  localparam bit IncEn = 1'b0;
`endif

  state_t        state, state_nxt;
  logic [3:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [W-1:0]  ac_q, dr_q;
  logic          e_q, ovf_q, done_q, err_q, skip_q;
  logic          accept, cmd_mem, cmd_reg, cmd_illegal;
  logic [W-1:0]  alu_b, alu_y;
  logic          alu_co, alu_ovf;

  assign accept      = cmd_valid && (state == ST_IDLE);
  assign cmd_mem     = is_mem_op(cmd_op);
  assign cmd_reg     = ((cmd_op >= OP_CMA) && (cmd_op <= OP_SZA)) || (IncEn && (cmd_op == OP_INC));
  assign cmd_illegal = !cmd_mem && !cmd_reg;

  // INC drives a constant 1 into the adder instead of DR; DR itself is untouched.
  assign alu_b = (IncEn && (op_q == OP_INC)) ? W'(1) : dr_q;

  alu_exec_ctrl_alu #(.W(W)) u_alu (
    .a      (ac_q),
    .b      (alu_b),
    .e_in   (e_q),
    .op_sel (alu_sel(op_q)),
    .y      (alu_y),
    .co     (alu_co),
    .ovf    (alu_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; register ops return straight to IDLE so the done cycle can accept.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_mem)      state_nxt = ST_MEM_RD;
          else if (cmd_reg) state_nxt = ST_EXEC;
          else              state_nxt = ST_DONE;
        end
      end
      ST_MEM_RD: if (mem_rvalid) state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_IDLE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, operand capture, architectural writeback and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      addr_q <= '0;
      dr_q   <= '0;
      ac_q   <= '0;
      e_q    <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      done_q <= (state == ST_EXEC) || (accept && cmd_illegal);
      err_q  <= accept && cmd_illegal;
      skip_q <= (state == ST_EXEC) && (op_q == OP_SZA) && (ac_q == '0);
      if (accept) begin
        op_q   <= cmd_op;
        addr_q <= cmd_addr;
      end
      if ((state == ST_MEM_RD) && mem_rvalid) dr_q <= mem_rdata;
      if (state == ST_EXEC) begin
        case (op_q)
          OP_ADD: begin
            ac_q  <= alu_y;
            e_q   <= alu_co;
            ovf_q <= alu_ovf;
          end
          OP_INC: begin
            ac_q  <= alu_y;
            ovf_q <= alu_ovf;
          end
          OP_AND, OP_LDA, OP_CMA, OP_CLA: begin
            ac_q  <= alu_y;
            ovf_q <= 1'b0;
          end
          OP_CIR, OP_CIL: begin
            ac_q  <= alu_y;
            e_q   <= alu_co;
            ovf_q <= 1'b0;
          end
          OP_CLE:  e_q <= 1'b0;
          OP_CME:  e_q <= ~e_q;
          default: ;
        endcase
      end
    end
  end

  assign cmd_ready = (state == ST_IDLE) && rst_n;
  assign mem_req   = (state == ST_MEM_RD);
  assign mem_addr  = addr_q;
  assign done      = done_q;
  assign err       = err_q;
  assign skip      = skip_q;
  assign ac        = ac_q;
  assign e         = e_q;
  assign ovf       = ovf_q;
  assign n         = ac_q[W-1];
  assign z         = (ac_q == '0);

endmodule
